// File: rtl/lap_stopwatch.sv
// Lap stopwatch: BCD up/down counter with start/stop, lap freeze and preset
// load driven by raw push buttons, plus a windowed 7-segment display.
module lap_stopwatch #(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 100,
    parameter int DIGITS  = 6,
    parameter int DISP    = 4
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  key_start_n,
    input  logic                  key_lap_n,
    input  logic                  key_load_n,
    input  logic                  dir_down,
    input  logic                  hi_window,
    input  logic [4*DIGITS-1:0]   preset_bcd,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic [7*DISP-1:0]     hex_n,
    output logic                  running,
    output logic                  lap_active,
    output logic                  done
);

    localparam int           DIV    = CLK_HZ / TICK_HZ;
    localparam int           PW     = $clog2(DIV);
    localparam logic [PW-1:0] PRE_TC = PW'(DIV - 1);

    // BCD increment with ripple carry; all-9s wraps to all-0s.
    function automatic logic [4*DIGITS-1:0] bcd_inc(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        logic                c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (c) begin
                if (v[4*i +: 4] >= 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return r;
    endfunction

    // BCD decrement with ripple borrow.
    function automatic logic [4*DIGITS-1:0] bcd_dec(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        logic                b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (b) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return r;
    endfunction

    // Any non-decimal preset digit is forced to 9.
    function automatic logic [4*DIGITS-1:0] bcd_clamp(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                r[4*i +: 4] = 4'd9;
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return r;
    endfunction

    // Active-low gfedcba segment decode.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // Key bit order: [0] start, [1] lap, [2] load.
    logic [2:0]          w_keys;
    logic [2:0]          r_sync1, r_sync2, r_hist, r_armed, r_ev;
    logic [1:0]          r_settle;
    logic [PW-1:0]       r_pre, w_pre_nx;
    logic [4*DIGITS-1:0] r_count, w_count_nx, r_lap, w_dec, w_src;
    logic                r_running, w_run_nx, r_lap_active, r_done, w_done_nx, w_tick;
    logic [3:0]          w_dig;
    logic [7*DISP-1:0]   w_hex;

    assign w_keys = {key_load_n, key_lap_n, key_start_n};

    // Synchronise keys and emit one registered pulse per falling edge. A key is
    // only armed once it has been seen released after reset, so a key held
    // through reset cannot fire when reset lifts.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_sync1  <= 3'b111;
            r_sync2  <= 3'b111;
            r_hist   <= 3'b111;
            r_armed  <= 3'b000;
            r_ev     <= 3'b000;
            r_settle <= 2'b00;
        end else begin
            r_sync1  <= w_keys;
            r_sync2  <= r_sync1;
            r_hist   <= r_sync2;
            r_settle <= {r_settle[0], 1'b1};
            r_armed  <= r_armed | (r_sync2 & {3{r_settle[1]}});
            r_ev     <= r_hist & ~r_sync2 & r_armed;
        end
    end

    assign w_tick = r_running && (r_pre == PRE_TC);
    assign w_dec  = bcd_dec(r_count);

    // Next-state for count, prescaler, run flag and expiry pulse.
    always_comb begin
        w_count_nx = r_count;
        w_pre_nx   = r_pre;
        w_run_nx   = r_running;
        w_done_nx  = 1'b0;
        if (r_running) begin
            if (w_tick) begin
                w_pre_nx = '0;
                if (dir_down) begin
                    w_count_nx = w_dec;
                    if (w_dec == '0) begin
                        w_run_nx  = 1'b0;
                        w_done_nx = 1'b1;
                    end else begin
                        w_done_nx = 1'b0;
                    end
                end else begin
                    w_count_nx = bcd_inc(r_count);
                end
            end else begin
                w_pre_nx = r_pre + PW'(1);
            end
            // Stop after counting any coincident tick; load is ignored while running.
            if (r_ev[0]) begin
                w_run_nx = 1'b0;
            end else begin
                w_run_nx = w_run_nx;
            end
        end else begin
            if (r_ev[2]) begin
                w_count_nx = bcd_clamp(preset_bcd);
                w_pre_nx   = '0;
            end else begin
                w_count_nx = r_count;
            end
            // Start uses the post-load value; a zero countdown cannot start.
            if (r_ev[0] && !(dir_down && (w_count_nx == '0))) begin
                w_run_nx = 1'b1;
            end else begin
                w_run_nx = 1'b0;
            end
        end
    end

    // Counter, prescaler, run flag and expiry pulse registers.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_count   <= '0;
            r_pre     <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_count   <= w_count_nx;
            r_pre     <= w_pre_nx;
            r_running <= w_run_nx;
            r_done    <= w_done_nx;
        end
    end

    // Lap capture takes the pre-tick count; a second lap releases the display.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_lap        <= '0;
            r_lap_active <= 1'b0;
        end else if (r_ev[1]) begin
            if (!r_lap_active) begin
                r_lap        <= r_count;
                r_lap_active <= 1'b1;
            end else begin
                r_lap_active <= 1'b0;
            end
        end else begin
            r_lap_active <= r_lap_active;
        end
    end

    // Select frozen or live value, apply the window and decode each digit.
    always_comb begin
        w_hex = '1;
        w_dig = 4'd0;
        w_src = r_lap_active ? r_lap : r_count;
        for (int g = 0; g < DISP; g++) begin
            if (hi_window) begin
                w_dig = w_src[4*(DIGITS-DISP+g) +: 4];
            end else begin
                w_dig = w_src[4*g +: 4];
            end
            w_hex[7*g +: 7] = seg7(w_dig);
        end
    end

    assign count_bcd  = r_count;
    assign hex_n      = w_hex;
    assign running    = r_running;
    assign lap_active = r_lap_active;
    assign done       = r_done;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Bench for lap_stopwatch: expected values queued as stimulus is applied,
// popped and compared when the DUT output is sampled (on falling edges).
module tb_lap_stopwatch;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic        key_start_n = 1'b1, key_lap_n = 1'b1, key_load_n = 1'b1;
    logic        dir_down = 1'b0, hi_window = 1'b0;
    logic [23:0] preset_bcd = 24'h000000;
    logic [23:0] count_bcd;
    logic [27:0] hex_n;
    logic        running, lap_active, done;

    int          total = 0;
    int          bad = 0;
    string       tag_q[$];
    logic [31:0] val_q[$];

    lap_stopwatch #(.CLK_HZ(1000), .TICK_HZ(100), .DIGITS(6), .DISP(4)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset),
        .key_start_n(key_start_n), .key_lap_n(key_lap_n), .key_load_n(key_load_n),
        .dir_down(dir_down), .hi_window(hi_window), .preset_bcd(preset_bcd),
        .count_bcd(count_bcd), .hex_n(hex_n),
        .running(running), .lap_active(lap_active), .done(done)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_val(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        val_q.push_back(v);
    endtask

    task automatic pop_cmp(input logic [31:0] obs);
        if (val_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_underflow: got %h expected <nothing queued>", obs);
        end else begin
            check_val(tag_q.pop_front(), obs, val_q.pop_front());
        end
    endtask

    function automatic logic [6:0] seg(input logic [3:0] d);
        logic [6:0] t [0:9];
        t[0] = 7'b1000000; t[1] = 7'b1111001; t[2] = 7'b0100100; t[3] = 7'b0110000;
        t[4] = 7'b0011001; t[5] = 7'b0010010; t[6] = 7'b0000010; t[7] = 7'b1111000;
        t[8] = 7'b0000000; t[9] = 7'b0010000;
        return (d <= 4'd9) ? t[d] : 7'b1111111;
    endfunction

    function automatic logic [31:0] disp_exp(input logic [23:0] v, input logic hi);
        logic [27:0] r;
        for (int i = 0; i < 4; i++) begin
            r[7*i +: 7] = seg(hi ? v[4*(i+2) +: 4] : v[4*i +: 4]);
        end
        return {4'h0, r};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    // m = {load, lap, start}; action lands on the 4th rising edge after the fall.
    task automatic press(input logic [2:0] m);
        key_start_n = ~m[0];
        key_lap_n   = ~m[1];
        key_load_n  = ~m[2];
        cyc(4);
        key_start_n = 1'b1;
        key_lap_n   = 1'b1;
        key_load_n  = 1'b1;
    endtask

    task automatic sample_basic;
        pop_cmp(32'(count_bcd));
        pop_cmp(32'(running));
    endtask

    initial begin
        // Reset state
        cyc(2);
        expect_val("rst_count", 32'h0); expect_val("rst_run", 32'h0);
        expect_val("rst_lap", 32'h0);   expect_val("rst_done", 32'h0);
        expect_val("rst_hex", disp_exp(24'h0, 1'b0));
        sample_basic(); pop_cmp(32'(lap_active)); pop_cmp(32'(done)); pop_cmp(32'(hex_n));
        reset = 1'b0;
        cyc(5);

        // Start, 250 cycles
        press(3'b001);
        expect_val("t27_count", 32'h25); expect_val("t27_run", 32'h1);
        expect_val("t27_hex", disp_exp(24'h000025, 1'b0));
        cyc(250);
        sample_basic(); pop_cmp(32'(hex_n));
        press(3'b001);
        expect_val("stop_count", 32'h25); expect_val("stop_run", 32'h0);
        cyc(20);
        sample_basic();

        // Up-count wrap with high window
        preset_bcd = 24'h999998;
        press(3'b100);
        cyc(3);
        expect_val("t28_load", 32'h999998);
        pop_cmp(32'(count_bcd));
        hi_window = 1'b1;
        press(3'b001);
        expect_val("t28_c1", 32'h999999); expect_val("t28_r1", 32'h1);
        expect_val("t28_h1", disp_exp(24'h999999, 1'b1));
        cyc(10);
        sample_basic(); pop_cmp(32'(hex_n));
        expect_val("t28_c2", 32'h000000); expect_val("t28_r2", 32'h1);
        expect_val("t28_h2", disp_exp(24'h000000, 1'b1));
        cyc(10);
        sample_basic(); pop_cmp(32'(hex_n));
        expect_val("t28_c3", 32'h000001); expect_val("t28_r3", 32'h1);
        cyc(10);
        sample_basic();
        hi_window = 1'b0;
        press(3'b001);
        cyc(3);

        // Countdown to expiry
        preset_bcd = 24'h000003;
        press(3'b100);
        cyc(3);
        dir_down = 1'b1;
        press(3'b001);
        expect_val("t29_c_pre", 32'h1); expect_val("t29_done_pre", 32'h0);
        cyc(29);
        pop_cmp(32'(count_bcd)); pop_cmp(32'(done));
        expect_val("t29_c_zero", 32'h0); expect_val("t29_run_zero", 32'h0);
        expect_val("t29_done", 32'h1);
        cyc(1);
        sample_basic(); pop_cmp(32'(done));
        expect_val("t29_done_clr", 32'h0);
        cyc(1);
        pop_cmp(32'(done));
        cyc(3);
        press(3'b001);
        expect_val("t29_ign_count", 32'h0); expect_val("t29_ign_run", 32'h0);
        expect_val("t29_ign_done", 32'h0);
        sample_basic(); pop_cmp(32'(done));

        // Lap freeze, release, and lap coincident with a tick
        dir_down = 1'b0;
        cyc(3);
        press(3'b001);
        cyc(118);
        press(3'b010);
        expect_val("t30_lap_on", 32'h1); expect_val("t30_hex12", disp_exp(24'h000012, 1'b0));
        pop_cmp(32'(lap_active)); pop_cmp(32'(hex_n));
        expect_val("t30_count62", 32'h62); expect_val("t30_frozen", disp_exp(24'h000012, 1'b0));
        cyc(498);
        pop_cmp(32'(count_bcd)); pop_cmp(32'(hex_n));
        cyc(2);
        press(3'b010);
        expect_val("t30_lap_off", 32'h0); expect_val("t30_hex62", disp_exp(24'h000062, 1'b0));
        pop_cmp(32'(lap_active)); pop_cmp(32'(hex_n));
        cyc(10);
        press(3'b010);
        expect_val("lap_tick_count", 32'h64); expect_val("lap_tick_hex", disp_exp(24'h000063, 1'b0));
        pop_cmp(32'(count_bcd)); pop_cmp(32'(hex_n));

        // Reset mid-count with lap active, start key held through release
        cyc(5);
        key_start_n = 1'b0;
        reset = 1'b1;
        #1;
        expect_val("t31_count", 32'h0); expect_val("t31_run", 32'h0);
        expect_val("t31_lap", 32'h0);   expect_val("t31_hex", disp_exp(24'h0, 1'b0));
        sample_basic(); pop_cmp(32'(lap_active)); pop_cmp(32'(hex_n));
        cyc(2);
        reset = 1'b0;
        expect_val("t31_held_run", 32'h0);
        cyc(20);
        pop_cmp(32'(running));
        key_start_n = 1'b1;
        expect_val("t31_rel_run", 32'h0);
        cyc(5);
        pop_cmp(32'(running));
        press(3'b001);
        expect_val("t31_rearm", 32'h1);
        pop_cmp(32'(running));

        // Load ignored while running, clamp on stopped load, load+start together
        preset_bcd = 24'h00C5C7;
        cyc(3);
        press(3'b100);
        expect_val("t32_ign_count", 32'h0);
        pop_cmp(32'(count_bcd));
        expect_val("t32_pre_kept", 32'h1);
        cyc(3);
        pop_cmp(32'(count_bcd));
        press(3'b001);
        cyc(3);
        press(3'b100);
        expect_val("t32_clamp", 32'h009597);
        cyc(3);
        pop_cmp(32'(count_bcd));
        preset_bcd = 24'h000100;
        press(3'b101);
        expect_val("ld_st_count", 32'h000100); expect_val("ld_st_run", 32'h1);
        sample_basic();
        expect_val("ld_st_tick", 32'h000101);
        cyc(10);
        pop_cmp(32'(count_bcd));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lap_stopwatch.md
LAP_STOPWATCH -- requirements
Module: lap_stopwatch

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, meaning the CLOCK_50 frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 100, meaning the count increment rate in Hz; CLK_HZ/TICK_HZ SHALL be an integer >= 2.
REQ-003 SHALL have parameter DIGITS, default 6, meaning the number of BCD counter digits (>= DISP).
REQ-004 SHALL have parameter DISP, default 4, meaning the number of 7-segment digits driven.
REQ-005 SHALL have port CLOCK_50  input  1  system clock, all state updates on the rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port key_start_n  input  1  raw active-low start/stop button, asynchronous to CLOCK_50.
REQ-008 SHALL have port key_lap_n  input  1  raw active-low lap button, asynchronous.
REQ-009 SHALL have port key_load_n  input  1  raw active-low preset-load button, asynchronous.
REQ-010 SHALL have port dir_down  input  1  static level: 0 = count up, 1 = count down.
REQ-011 SHALL have port hi_window  input  1  display select: 0 = digits DISP-1..0, 1 = digits DIGITS-1..DIGITS-DISP.
REQ-012 SHALL have port preset_bcd  input  4*DIGITS  BCD load value, digit 0 in bits [3:0].
REQ-013 SHALL have port count_bcd  output  4*DIGITS  live counter value, digit 0 in bits [3:0].
REQ-014 SHALL have port hex_n  output  7*DISP  active-low segments gfedcba, display digit 0 in bits [6:0].
REQ-015 SHALL have port running, lap_active, done  output  1 each: run state, display frozen, countdown-expiry pulse.

Function
REQ-016 Each key SHALL pass through a 2-flop synchroniser plus one history flop; a press event SHALL be a 1-cycle pulse when the synchronised level goes 1->0, and its action SHALL take effect on the next edge (4 cycles after the pin falls).
REQ-017 Prescaler SHALL count 0..CLK_HZ/TICK_HZ-1 while running and emit a 1-cycle tick at terminal count, then wrap to 0; it SHALL hold its value (not clear) while stopped.
REQ-018 On tick with dir_down=0 the counter SHALL increment in BCD with ripple carry; all-9s SHALL wrap to all-0s and keep running.
REQ-019 On tick with dir_down=1 the counter SHALL decrement in BCD with borrow; on reaching all-0s, running SHALL clear and done SHALL pulse for exactly 1 cycle on the same edge.
REQ-020 A start event SHALL toggle running, except it SHALL be ignored when dir_down=1 and the count is all-0s (running stays 0, no done).
REQ-021 A load event SHALL be honoured only while stopped: count_bcd <= preset_bcd with any digit > 9 clamped to 9, prescaler cleared; ignored while running.
REQ-022 A lap event with lap_active=0 SHALL capture count_bcd into a lap register and set lap_active; with lap_active=1 it SHALL clear lap_active. The counter SHALL continue unaffected.
REQ-023 hex_n SHALL show the lap register when lap_active=1, otherwise count_bcd, windowed by hi_window; the decode SHALL be 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, other=1111111; the output SHALL be combinational from registers.
REQ-024 Simultaneous events: a tick and a stop in the same cycle SHALL count the tick; a lap and a tick SHALL capture the pre-tick value; load and start in the same cycle while stopped SHALL load and then start; a start and expiry in the same cycle SHALL result in stopped.

Reset
REQ-025 reset SHALL asynchronously clear the counter, prescaler, lap register, running, lap_active, done and the synchroniser/history flops to idle (1); hex_n SHALL read 1000000 per digit.
REQ-026 reset asserted mid-count or mid-lap SHALL abort immediately; after release, no event SHALL be generated from keys held low during reset until they are released and pressed again.

Verification (CLK_HZ=1000, TICK_HZ=100, DIGITS=6, DISP=4)
REQ-027 Press start, wait 250 cycles -> count_bcd=000025, running=1, hex_n shows 0025.
REQ-028 Preload 999998, count up 3 ticks -> 999999, 000000, 000001; running stays 1; hi_window=1 shows 9999 then 0000.
REQ-029 Load 000003, dir_down=1, start -> after 3 ticks count=000000, done high for 1 cycle, running=0; a further start is ignored.
REQ-030 Lap at count 000012, run 50 more ticks -> hex_n frozen at 0012, count_bcd=000062; second lap -> display 0062.
REQ-031 Assert reset at count 000040 with lap_active=1 -> all outputs zero/idle within the same cycle; hold key_start_n low through release -> running stays 0.
REQ-032 Load pressed while running -> count unchanged; preset digit value 0xC -> loaded as 9.
